// File: rtl/taxi_axi_arbiter_rd.sv
// AXI4 read-path N:1 arbiter. Registered AR stage with the source index prepended to ARID.
// R beats are steered back combinationally by that prefix. Per-source outstanding-burst limiting is included.
module taxi_axi_arbiter_rd #(
    parameter int S_COUNT         = 4,
    parameter int S_ID_W          = 8,
    parameter int CL_S_COUNT      = $clog2(S_COUNT),
    parameter int M_ID_W          = S_ID_W + CL_S_COUNT,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int ARUSER_W        = 1,
    parameter int RUSER_W         = 1,
    parameter bit ARB_ROUND_ROBIN = 1'b1,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,

    input  logic [S_COUNT-1:0][S_ID_W-1:0]     s_axi_arid,
    input  logic [S_COUNT-1:0][ADDR_W-1:0]     s_axi_araddr,
    input  logic [S_COUNT-1:0][7:0]            s_axi_arlen,
    input  logic [S_COUNT-1:0][2:0]            s_axi_arsize,
    input  logic [S_COUNT-1:0][1:0]            s_axi_arburst,
    input  logic [S_COUNT-1:0]                 s_axi_arlock,
    input  logic [S_COUNT-1:0][3:0]            s_axi_arcache,
    input  logic [S_COUNT-1:0][2:0]            s_axi_arprot,
    input  logic [S_COUNT-1:0][3:0]            s_axi_arqos,
    input  logic [S_COUNT-1:0][3:0]            s_axi_arregion,
    input  logic [S_COUNT-1:0][ARUSER_W-1:0]   s_axi_aruser,
    input  logic [S_COUNT-1:0]                 s_axi_arvalid,
    output logic [S_COUNT-1:0]                 s_axi_arready,

    output logic [S_COUNT-1:0][S_ID_W-1:0]     s_axi_rid,
    output logic [S_COUNT-1:0][DATA_W-1:0]     s_axi_rdata,
    output logic [S_COUNT-1:0][1:0]            s_axi_rresp,
    output logic [S_COUNT-1:0]                 s_axi_rlast,
    output logic [S_COUNT-1:0][RUSER_W-1:0]    s_axi_ruser,
    output logic [S_COUNT-1:0]                 s_axi_rvalid,
    input  logic [S_COUNT-1:0]                 s_axi_rready,

    output logic [M_ID_W-1:0]                  m_axi_arid,
    output logic [ADDR_W-1:0]                  m_axi_araddr,
    output logic [7:0]                         m_axi_arlen,
    output logic [2:0]                         m_axi_arsize,
    output logic [1:0]                         m_axi_arburst,
    output logic                               m_axi_arlock,
    output logic [3:0]                         m_axi_arcache,
    output logic [2:0]                         m_axi_arprot,
    output logic [3:0]                         m_axi_arqos,
    output logic [3:0]                         m_axi_arregion,
    output logic [ARUSER_W-1:0]                m_axi_aruser,
    output logic                               m_axi_arvalid,
    input  logic                               m_axi_arready,

    input  logic [M_ID_W-1:0]                  m_axi_rid,
    input  logic [DATA_W-1:0]                  m_axi_rdata,
    input  logic [1:0]                         m_axi_rresp,
    input  logic                               m_axi_rlast,
    input  logic [RUSER_W-1:0]                 m_axi_ruser,
    input  logic                               m_axi_rvalid,
    output logic                               m_axi_rready
);

    localparam int AR_W  = ADDR_W + 29 + ARUSER_W;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    generate
        if (M_ID_W < S_ID_W + CL_S_COUNT) begin : g_id_width_check
            $error("m_axi ID width too narrow for source prefix");
        end
    endgenerate

    logic [S_COUNT-1:0][AR_W-1:0]  s_ar_pld;
    logic [S_COUNT-1:0]            eligible;
    logic [S_COUNT-1:0]            r_done;
    logic [S_COUNT-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [CL_S_COUNT-1:0]         rr_ptr_q, rr_ptr_d;
    logic [CL_S_COUNT-1:0]         grant_idx;
    logic                          grant_valid;
    logic                          ar_load;
    logic                          m_arvalid_q, m_arvalid_d;
    logic [M_ID_W-1:0]             m_arid_q, m_arid_d;
    logic [AR_W-1:0]               m_ar_pld_q, m_ar_pld_d;
    logic [CL_S_COUNT-1:0]         r_sel;
    logic                          r_sel_ok;
    logic                          m_rready_c;
    int                            idx;

    genvar gi;
    generate
        for (gi = 0; gi < S_COUNT; gi++) begin : g_src
            assign s_ar_pld[gi] = {s_axi_araddr[gi], s_axi_arlen[gi], s_axi_arsize[gi],
                                   s_axi_arburst[gi], s_axi_arlock[gi], s_axi_arcache[gi],
                                   s_axi_arprot[gi], s_axi_arqos[gi], s_axi_arregion[gi],
                                   s_axi_aruser[gi]};
            assign eligible[gi]      = s_axi_arvalid[gi] && (cnt_q[gi] != CNT_W'(MAX_OUTSTANDING));
            assign s_axi_arready[gi] = ar_load && (grant_idx == CL_S_COUNT'(gi));

            assign s_axi_rid[gi]    = m_axi_rid[S_ID_W-1:0];
            assign s_axi_rdata[gi]  = m_axi_rdata;
            assign s_axi_rresp[gi]  = m_axi_rresp;
            assign s_axi_rlast[gi]  = m_axi_rlast;
            assign s_axi_ruser[gi]  = m_axi_ruser;
            assign s_axi_rvalid[gi] = m_axi_rvalid && r_sel_ok && (int'(r_sel) == gi);
            assign r_done[gi]       = s_axi_rvalid[gi] && s_axi_rready[gi] && m_axi_rlast;
        end
    endgenerate

    // Rotating search; fixed priority simply always starts from index 0.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < S_COUNT; k++) begin
            idx = (ARB_ROUND_ROBIN ? int'(rr_ptr_q) : 0) + k;
            if (idx >= S_COUNT) begin
                idx = idx - S_COUNT;
            end
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = CL_S_COUNT'(idx);
            end
        end
    end

    // Gating with rst_n keeps every arready low while reset is held.
    assign ar_load = grant_valid && rst_n && (!m_arvalid_q || m_axi_arready);

    always_comb begin
        m_arvalid_d = m_arvalid_q;
        rr_ptr_d    = rr_ptr_q;
        m_arid_d    = m_arid_q;
        m_ar_pld_d  = m_ar_pld_q;
        if (m_axi_arready) begin
            m_arvalid_d = 1'b0;
        end
        if (ar_load) begin
            m_arvalid_d = 1'b1;
            rr_ptr_d    = (int'(grant_idx) == S_COUNT - 1) ? '0 : grant_idx + 1'b1;
            m_arid_d    = '0;
            m_arid_d[S_ID_W +: CL_S_COUNT] = grant_idx;
            m_arid_d[S_ID_W-1:0]           = s_axi_arid[grant_idx];
            m_ar_pld_d  = s_ar_pld[grant_idx];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < S_COUNT; i++) begin
            if (s_axi_arready[i] && !r_done[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (!s_axi_arready[i] && r_done[i] && cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    // Beats whose prefix names no source are swallowed so a bad slave cannot stall R.
    assign r_sel    = m_axi_rid[S_ID_W +: CL_S_COUNT];
    assign r_sel_ok = (int'(r_sel) < S_COUNT);

    always_comb begin
        m_rready_c = !r_sel_ok;
        for (int i = 0; i < S_COUNT; i++) begin
            if (r_sel_ok && int'(r_sel) == i && s_axi_rready[i]) begin
                m_rready_c = 1'b1;
            end
        end
    end

    assign m_axi_rready = m_rready_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_arvalid_q <= 1'b0;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            m_arid_q    <= '0;
            m_ar_pld_q  <= '0;
        end else begin
            m_arvalid_q <= m_arvalid_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            m_arid_q    <= m_arid_d;
            m_ar_pld_q  <= m_ar_pld_d;
        end
    end

    assign m_axi_arvalid = m_arvalid_q;
    assign m_axi_arid    = m_arid_q;
    assign {m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
            m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arregion, m_axi_aruser} = m_ar_pld_q;

endmodule

// File: tb/tb_taxi_axi_arbiter_rd.sv
// Directed bench for taxi_axi_arbiter_rd: a vector table for RR grants and R steering,
// plus hand sequences for reset, backpressure, outstanding limits and bad IDs.
module tb_taxi_axi_arbiter_rd;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 4-port instance, outstanding limit 2
    logic [3:0][7:0]  s_arid;
    logic [3:0][31:0] s_araddr;
    logic [3:0][7:0]  s_arlen;
    logic [3:0][2:0]  s_arsize;
    logic [3:0][1:0]  s_arburst;
    logic [3:0]       s_arlock;
    logic [3:0][3:0]  s_arcache;
    logic [3:0][2:0]  s_arprot;
    logic [3:0][3:0]  s_arqos;
    logic [3:0][3:0]  s_arregion;
    logic [3:0][0:0]  s_aruser;
    logic [3:0]       s_arvalid;
    logic [3:0]       s_arready;
    logic [3:0][7:0]  s_rid;
    logic [3:0][31:0] s_rdata;
    logic [3:0][1:0]  s_rresp;
    logic [3:0]       s_rlast;
    logic [3:0][0:0]  s_ruser;
    logic [3:0]       s_rvalid;
    logic [3:0]       s_rready;
    logic [9:0]       m_arid;
    logic [31:0]      m_araddr;
    logic [7:0]       m_arlen;
    logic [2:0]       m_arsize;
    logic [1:0]       m_arburst;
    logic             m_arlock;
    logic [3:0]       m_arcache;
    logic [2:0]       m_arprot;
    logic [3:0]       m_arqos;
    logic [3:0]       m_arregion;
    logic [0:0]       m_aruser;
    logic             m_arvalid;
    logic             m_arready;
    logic [9:0]       m_rid;
    logic [31:0]      m_rdata;
    logic [1:0]       m_rresp;
    logic             m_rlast;
    logic [0:0]       m_ruser;
    logic             m_rvalid;
    logic             m_rready;

    // 3-port instance, used for the out-of-range prefix case
    logic [2:0]       t_arready;
    logic [2:0][7:0]  t_rid;
    logic [2:0][31:0] t_rdata;
    logic [2:0][1:0]  t_rresp;
    logic [2:0]       t_rlast;
    logic [2:0][0:0]  t_ruser;
    logic [2:0]       t_rvalid;
    logic [2:0]       t_rready;
    logic [9:0]       t_m_arid;
    logic [31:0]      t_m_araddr;
    logic [7:0]       t_m_arlen;
    logic [2:0]       t_m_arsize;
    logic [1:0]       t_m_arburst;
    logic             t_m_arlock;
    logic [3:0]       t_m_arcache;
    logic [2:0]       t_m_arprot;
    logic [3:0]       t_m_arqos;
    logic [3:0]       t_m_arregion;
    logic [0:0]       t_m_aruser;
    logic             t_m_arvalid;
    logic [9:0]       t_m_rid;
    logic             t_m_rvalid;
    logic             t_m_rready;

    taxi_axi_arbiter_rd #(
        .S_COUNT(4), .S_ID_W(8), .M_ID_W(10), .ADDR_W(32), .DATA_W(32),
        .ARUSER_W(1), .RUSER_W(1), .ARB_ROUND_ROBIN(1'b1), .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_arid(s_arid), .s_axi_araddr(s_araddr), .s_axi_arlen(s_arlen),
        .s_axi_arsize(s_arsize), .s_axi_arburst(s_arburst), .s_axi_arlock(s_arlock),
        .s_axi_arcache(s_arcache), .s_axi_arprot(s_arprot), .s_axi_arqos(s_arqos),
        .s_axi_arregion(s_arregion), .s_axi_aruser(s_aruser), .s_axi_arvalid(s_arvalid),
        .s_axi_arready(s_arready),
        .s_axi_rid(s_rid), .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp), .s_axi_rlast(s_rlast),
        .s_axi_ruser(s_ruser), .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready),
        .m_axi_arid(m_arid), .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen),
        .m_axi_arsize(m_arsize), .m_axi_arburst(m_arburst), .m_axi_arlock(m_arlock),
        .m_axi_arcache(m_arcache), .m_axi_arprot(m_arprot), .m_axi_arqos(m_arqos),
        .m_axi_arregion(m_arregion), .m_axi_aruser(m_aruser), .m_axi_arvalid(m_arvalid),
        .m_axi_arready(m_arready),
        .m_axi_rid(m_rid), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast),
        .m_axi_ruser(m_ruser), .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready)
    );

    taxi_axi_arbiter_rd #(
        .S_COUNT(3), .S_ID_W(8), .M_ID_W(10), .ADDR_W(32), .DATA_W(32),
        .ARUSER_W(1), .RUSER_W(1), .ARB_ROUND_ROBIN(1'b1), .MAX_OUTSTANDING(16)
    ) dut3 (
        .clk(clk), .rst_n(rst_n),
        .s_axi_arid('0), .s_axi_araddr('0), .s_axi_arlen('0),
        .s_axi_arsize('0), .s_axi_arburst('0), .s_axi_arlock('0),
        .s_axi_arcache('0), .s_axi_arprot('0), .s_axi_arqos('0),
        .s_axi_arregion('0), .s_axi_aruser('0), .s_axi_arvalid(3'b000),
        .s_axi_arready(t_arready),
        .s_axi_rid(t_rid), .s_axi_rdata(t_rdata), .s_axi_rresp(t_rresp), .s_axi_rlast(t_rlast),
        .s_axi_ruser(t_ruser), .s_axi_rvalid(t_rvalid), .s_axi_rready(t_rready),
        .m_axi_arid(t_m_arid), .m_axi_araddr(t_m_araddr), .m_axi_arlen(t_m_arlen),
        .m_axi_arsize(t_m_arsize), .m_axi_arburst(t_m_arburst), .m_axi_arlock(t_m_arlock),
        .m_axi_arcache(t_m_arcache), .m_axi_arprot(t_m_arprot), .m_axi_arqos(t_m_arqos),
        .m_axi_arregion(t_m_arregion), .m_axi_aruser(t_m_aruser), .m_axi_arvalid(t_m_arvalid),
        .m_axi_arready(1'b0),
        .m_axi_rid(t_m_rid), .m_axi_rdata(32'h0), .m_axi_rresp(2'b00), .m_axi_rlast(1'b1),
        .m_axi_ruser(1'b0), .m_axi_rvalid(t_m_rvalid), .m_axi_rready(t_m_rready)
    );

    int total_cnt = 0;
    int pass_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    typedef struct {
        logic [3:0] arv;
        logic       mrdy;
        logic       rv;
        logic [9:0] rid;
        logic       rl;
        logic [3:0] rr;
        logic [3:0] e_ardy;
        logic       e_mv;
        logic [9:0] e_mid;
        logic       chk_id;
        logic [3:0] e_rv;
        logic       e_mrr;
    } vec_t;

    vec_t tbl [14];

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        s_arvalid = '0;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        m_rid     = '0;
        s_rready  = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int pulses;
    int addr_moves;

    initial begin
        // RR sweep twice until every port hits its limit of 2, then R steering.
        tbl[0]  = '{4'hF, 1'b1, 1'b0, 10'h000, 1'b0, 4'hF, 4'h1, 1'b1, 10'h0A0, 1'b1, 4'h0, 1'b1};
        tbl[1]  = '{4'hF, 1'b1, 1'b0, 10'h000, 1'b0, 4'hF, 4'h2, 1'b1, 10'h1A1, 1'b1, 4'h0, 1'b1};
        tbl[2]  = '{4'hF, 1'b1, 1'b0, 10'h000, 1'b0, 4'hF, 4'h4, 1'b1, 10'h2A2, 1'b1, 4'h0, 1'b1};
        tbl[3]  = '{4'hF, 1'b1, 1'b0, 10'h000, 1'b0, 4'hF, 4'h8, 1'b1, 10'h3A3, 1'b1, 4'h0, 1'b1};
        tbl[4]  = '{4'hF, 1'b1, 1'b0, 10'h000, 1'b0, 4'hF, 4'h1, 1'b1, 10'h0A0, 1'b1, 4'h0, 1'b1};
        tbl[5]  = '{4'hF, 1'b1, 1'b0, 10'h000, 1'b0, 4'hF, 4'h2, 1'b1, 10'h1A1, 1'b1, 4'h0, 1'b1};
        tbl[6]  = '{4'hF, 1'b1, 1'b0, 10'h000, 1'b0, 4'hF, 4'h4, 1'b1, 10'h2A2, 1'b1, 4'h0, 1'b1};
        tbl[7]  = '{4'hF, 1'b1, 1'b0, 10'h000, 1'b0, 4'hF, 4'h8, 1'b1, 10'h3A3, 1'b1, 4'h0, 1'b1};
        tbl[8]  = '{4'hF, 1'b1, 1'b0, 10'h000, 1'b0, 4'hF, 4'h0, 1'b0, 10'h000, 1'b0, 4'h0, 1'b1};
        tbl[9]  = '{4'hF, 1'b1, 1'b1, 10'h200, 1'b1, 4'hF, 4'h0, 1'b0, 10'h000, 1'b0, 4'h4, 1'b1};
        tbl[10] = '{4'hF, 1'b1, 1'b0, 10'h000, 1'b0, 4'hF, 4'h4, 1'b1, 10'h2A2, 1'b1, 4'h0, 1'b1};
        tbl[11] = '{4'h0, 1'b0, 1'b1, 10'h305, 1'b0, 4'h7, 4'h0, 1'b1, 10'h2A2, 1'b1, 4'h8, 1'b0};
        tbl[12] = '{4'h0, 1'b1, 1'b1, 10'h305, 1'b0, 4'hF, 4'h0, 1'b0, 10'h000, 1'b0, 4'h8, 1'b1};
        tbl[13] = '{4'h0, 1'b0, 1'b1, 10'h100, 1'b1, 4'h0, 4'h0, 1'b0, 10'h000, 1'b0, 4'h2, 1'b0};

        for (int i = 0; i < 4; i++) begin
            s_arid[i]     = 8'hA0 + 8'(i);
            s_araddr[i]   = 32'h0001_0000 * (i + 1);
            s_arlen[i]    = 8'h10 + 8'(i);
            s_arsize[i]   = 3'(i);
            s_arburst[i]  = 2'b01;
            s_arlock[i]   = 1'b0;
            s_arcache[i]  = 4'h3;
            s_arprot[i]   = 3'(i + 1);
            s_arqos[i]    = 4'(i);
            s_arregion[i] = 4'h0;
            s_aruser[i]   = 1'(i);
        end
        s_arvalid = 4'hF;
        s_rready  = '0;
        m_arready = 1'b0;
        m_rid     = '0;
        m_rdata   = 32'hDEAD_BEEF;
        m_rresp   = 2'b00;
        m_rlast   = 1'b0;
        m_ruser   = 1'b0;
        m_rvalid  = 1'b0;
        t_m_rid    = '0;
        t_m_rvalid = 1'b0;
        t_rready   = '0;

        // Reset held with all requesters active
        repeat (2) @(negedge clk);
        #1;
        chk("rst_m_arvalid", 32'(m_arvalid), 32'h0);
        chk("rst_s_arready", 32'(s_arready), 32'h0);
        s_arvalid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 14; v++) begin
            @(negedge clk);
            s_arvalid = tbl[v].arv;
            m_arready = tbl[v].mrdy;
            m_rvalid  = tbl[v].rv;
            m_rid     = tbl[v].rid;
            m_rlast   = tbl[v].rl;
            s_rready  = tbl[v].rr;
            #1;
            chk($sformatf("v%0d_s_arready", v), 32'(s_arready), 32'(tbl[v].e_ardy));
            chk($sformatf("v%0d_s_rvalid", v), 32'(s_rvalid), 32'(tbl[v].e_rv));
            chk($sformatf("v%0d_m_rready", v), 32'(m_rready), 32'(tbl[v].e_mrr));
            if (tbl[v].rv) begin
                chk($sformatf("v%0d_s_rid3", v), 32'(s_rid[3]), 32'(tbl[v].rid[7:0]));
            end
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_m_arvalid", v), 32'(m_arvalid), 32'(tbl[v].e_mv));
            if (tbl[v].chk_id) begin
                chk($sformatf("v%0d_m_arid", v), 32'(m_arid), 32'(tbl[v].e_mid));
            end
        end

        // Backpressure: one load, payload held until handshake
        do_reset();
        @(negedge clk);
        s_araddr[2] = 32'h0000_1000;
        s_arvalid   = 4'b0100;
        m_arready   = 1'b0;
        #1;
        chk("bp_first_arready", 32'(s_arready), 32'h4);
        @(posedge clk);
        #1;
        chk("bp_m_arvalid", 32'(m_arvalid), 32'h1);
        chk("bp_m_araddr", m_araddr, 32'h0000_1000);
        chk("bp_m_arid", 32'(m_arid), 32'h2A2);
        chk("bp_m_arlen", 32'(m_arlen), 32'h12);
        chk("bp_m_arprot", 32'(m_arprot), 32'h3);
        @(negedge clk);
        s_araddr[2] = 32'h0000_2000;
        pulses      = 0;
        addr_moves  = 0;
        repeat (5) begin
            #1;
            if (s_arready != 4'h0) pulses++;
            @(posedge clk);
            #1;
            if (m_araddr != 32'h0000_1000 || !m_arvalid) addr_moves++;
            @(negedge clk);
        end
        chk("bp_extra_arready", 32'(pulses), 32'h0);
        chk("bp_payload_moved", 32'(addr_moves), 32'h0);
        m_arready = 1'b1;
        #1;
        chk("bp_reload_arready", 32'(s_arready), 32'h4);
        @(posedge clk);
        #1;
        chk("bp_next_addr", m_araddr, 32'h0000_2000);
        s_arvalid   = '0;
        s_araddr[2] = 32'h0003_0000;

        // Outstanding limit on port 1 while port 0 keeps being served
        do_reset();
        @(negedge clk);
        s_arvalid = 4'b0010;
        m_arready = 1'b1;
        s_rready  = 4'hF;
        #1;
        chk("lim_p1_first", 32'(s_arready), 32'h2);
        @(negedge clk);
        #1;
        chk("lim_p1_second", 32'(s_arready), 32'h2);
        @(negedge clk);
        s_arvalid = 4'b0011;
        #1;
        chk("lim_p1_blocked", 32'(s_arready), 32'h1);
        @(negedge clk);
        m_rvalid = 1'b1;
        m_rid    = 10'h100;
        m_rlast  = 1'b1;
        #1;
        chk("lim_rlast_rvalid", 32'(s_rvalid), 32'h2);
        chk("lim_still_blocked", 32'(s_arready), 32'h1);
        @(negedge clk);
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        #1;
        chk("lim_p1_resumed", 32'(s_arready), 32'h2);

        // Same-cycle load and rlast on port 0 leaves the count unchanged
        do_reset();
        @(negedge clk);
        s_arvalid = 4'b0001;
        m_arready = 1'b1;
        s_rready  = 4'hF;
        #1;
        chk("id_load1", 32'(s_arready), 32'h1);
        @(negedge clk);
        m_rvalid = 1'b1;
        m_rid    = 10'h000;
        m_rlast  = 1'b1;
        #1;
        chk("id_load_and_done", 32'(s_arready), 32'h1);
        chk("id_m_rready", 32'(m_rready), 32'h1);
        @(negedge clk);
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        #1;
        chk("id_load_to_limit", 32'(s_arready), 32'h1);
        @(negedge clk);
        #1;
        chk("id_blocked", 32'(s_arready), 32'h0);
        s_arvalid = '0;

        // 3-port instance: prefix 3 is dropped, prefix 2 is steered
        t_m_rvalid = 1'b1;
        t_m_rid    = 10'h3AB;
        t_rready   = 3'b000;
        #1;
        chk("bad_m_rready", 32'(t_m_rready), 32'h1);
        chk("bad_s_rvalid", 32'(t_rvalid), 32'h0);
        t_m_rid = 10'h2AB;
        #1;
        chk("p2_s_rvalid", 32'(t_rvalid), 32'h4);
        chk("p2_m_rready_lo", 32'(t_m_rready), 32'h0);
        chk("p2_s_rid", 32'(t_rid[2]), 32'hAB);
        t_rready = 3'b100;
        #1;
        chk("p2_m_rready_hi", 32'(t_m_rready), 32'h1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
